// File: rtl/pll_phase_pkg.sv
// Shared types and helpers for the PLL dynamic-phase controller.
package pll_phase_pkg;

    // Phase width the shared arithmetic is sized for; the top-level default matches it.
    localparam int PHASE_W_DEF = 7;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SETUP,
        ST_STEP,
        ST_LOAD,
        ST_WAIT_LOCK,
        ST_DONE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_STEP_LO,
        PS_STEP_HI
    } pulse_state_t;

    // One extra bit so tgt + max never overflows.
    typedef logic [PHASE_W_DEF:0] dphase_t;

    typedef struct packed {
        logic    dir;
        dphase_t count;
    } delta_t;

    // Shortest way round the phase circle; a tie goes forward.
    function automatic delta_t wrap_delta(input dphase_t cur, input dphase_t tgt, input dphase_t max);
        dphase_t fwd;
        dphase_t rev;
        delta_t  d;
        fwd = (tgt >= cur) ? (tgt - cur) : (tgt + max - cur);
        rev = max - fwd;
        if (fwd <= rev) begin
            d.dir   = DIR_INC;
            d.count = fwd;
        end else begin
            d.dir   = DIR_DEC;
            d.count = rev;
        end
        return d;
    endfunction

endpackage

// File: rtl/pll_step_pulser.sv
// Generates the active-low PHASE_STEP_N pulse train for a given number of steps.
module pll_step_pulser #(
    parameter int CNT_W    = 7,
    parameter int STEP_LOW = 2,
    parameter int STEP_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             step_n,
    output logic             step,
    output logic             last_step
);
    import pll_phase_pkg::*;

    localparam int TW = $clog2(((STEP_LOW > STEP_GAP) ? STEP_LOW : STEP_GAP) + 1);

    pulse_state_t     ps;
    pulse_state_t     ps_nxt;
    logic [TW-1:0]    tmr;
    logic [CNT_W-1:0] remain;
    logic             tmr_zero;

    assign tmr_zero = (tmr == '0);

    // Pulse-phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) ps <= PS_IDLE;
        else        ps <= ps_nxt;
    end

    // Low/high alternation; the last high period returns to idle.
    always_comb begin
        ps_nxt = ps;
        case (ps)
            PS_IDLE:    if (start && (count != '0)) ps_nxt = PS_STEP_LO;
            PS_STEP_LO: if (tmr_zero) ps_nxt = PS_STEP_HI;
            PS_STEP_HI: if (tmr_zero) ps_nxt = (remain == '0) ? PS_IDLE : PS_STEP_LO;
            default:    ps_nxt = PS_IDLE;
        endcase
    end

    // Down-counting phase timer and remaining-step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr    <= '0;
            remain <= '0;
        end else begin
            if ((ps_nxt == PS_STEP_LO) && (ps != PS_STEP_LO))
                tmr <= TW'(STEP_LOW - 1);
            else if ((ps_nxt == PS_STEP_HI) && (ps != PS_STEP_HI))
                tmr <= TW'(STEP_GAP - 1);
            else if (!tmr_zero)
                tmr <= tmr - TW'(1);

            if ((ps == PS_IDLE) && start)
                remain <= count;
            else if (step)
                remain <= remain - CNT_W'(1);
        end
    end

    // A step is counted as it leaves the low phase.
    always_comb begin
        step_n    = (ps != PS_STEP_LO);
        step      = (ps == PS_STEP_LO) && tmr_zero;
        last_step = (ps == PS_STEP_HI) && tmr_zero && (remain == '0);
    end

endmodule

// File: rtl/pll_dyn_phase_ctrl.sv
// Run-time phase controller for the PLL dynamic-phase interface.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready for a request
// CALC       | shortest direction and step count from tracked phase
// SETUP      | phase_sel / phase_dir settle one cycle before stepping
// STEP       | step pulser running; tracked phase moves per step
// LOAD       | one-cycle load_phase commit
// WAIT_LOCK  | wait for pll_lock, bounded by LOCK_TIMEOUT
// DONE       | one-cycle done (err on reject or lock timeout)
module pll_dyn_phase_ctrl #(
    parameter int NUM_CH       = 2,
    parameter int PHASE_W      = 7,
    parameter int MAX_PHASE    = 40,
    parameter int STEP_LOW     = 2,
    parameter int STEP_GAP     = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_ch,
    input  logic [PHASE_W-1:0]        req_phase,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [NUM_CH*PHASE_W-1:0] cur_phase,
    input  logic                      pll_lock,
    output logic [2:0]                phase_sel,
    output logic                      phase_dir,
    output logic                      phase_step_n,
    output logic                      load_phase
);
    import pll_phase_pkg::*;

    localparam int                 LT_W   = $clog2(LOCK_TIMEOUT) + 1;
    localparam int                 LAST_I = MAX_PHASE - 1;
    localparam logic [PHASE_W:0]   MAX_P  = MAX_PHASE[PHASE_W:0];
    localparam logic [PHASE_W-1:0] LAST_P = LAST_I[PHASE_W-1:0];
    localparam logic [3:0]         NCH_P  = NUM_CH[3:0];

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [2:0]         ch_q;
    logic [PHASE_W-1:0] tgt_q;
    logic               dir_q;
    logic [PHASE_W-1:0] cnt_q;
    logic               err_q;
    logic [LT_W-1:0]    lt_cnt;
    logic [PHASE_W-1:0] cur_q [NUM_CH];
    logic [PHASE_W-1:0] cur_sel;
    delta_t             delta;
    logic               accept;
    logic               req_ok;
    logic               step;
    logic               last_step;
    logic               step_n;

    pll_step_pulser #(
        .CNT_W    (PHASE_W),
        .STEP_LOW (STEP_LOW),
        .STEP_GAP (STEP_GAP)
    ) u_pulser (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (state == ST_SETUP),
        .count     (cnt_q),
        .step_n    (step_n),
        .step      (step),
        .last_step (last_step)
    );

    // Request acceptance, validation and the shortest-path delta for the selected channel.
    always_comb begin
        accept  = req_valid && (state == ST_IDLE);
        req_ok  = ({1'b0, req_ch} < NCH_P) && ({1'b0, req_phase} < MAX_P);
        cur_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_q == 3'(i)) cur_sel = cur_q[i];
        delta = wrap_delta(dphase_t'({1'b0, cur_sel}), dphase_t'({1'b0, tgt_q}), dphase_t'(MAX_P));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Sequencing from request to commit and lock.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (accept) state_nxt = req_ok ? ST_CALC : ST_DONE;
            ST_CALC:      state_nxt = (delta.count == '0) ? ST_DONE : ST_SETUP;
            ST_SETUP:     state_nxt = ST_STEP;
            ST_STEP:      if (last_step) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (pll_lock || (lt_cnt == '0)) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Captured request, computed move, lock timer and per-channel phase tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q   <= '0;
            tgt_q  <= '0;
            dir_q  <= DIR_DEC;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            lt_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) cur_q[i] <= '0;
        end else begin
            if (accept) begin
                err_q <= !req_ok;
                if (req_ok) begin
                    ch_q  <= req_ch;
                    tgt_q <= req_phase;
                end
            end

            if (state == ST_CALC) begin
                dir_q <= delta.dir;
                cnt_q <= delta.count[PHASE_W-1:0];
            end

            if (state == ST_LOAD) begin
                lt_cnt <= LT_W'(LOCK_TIMEOUT - 1);
            end else if (state == ST_WAIT_LOCK) begin
                if (pll_lock)
                    err_q <= 1'b0;
                else if (lt_cnt == '0)
                    err_q <= 1'b1;
                else
                    lt_cnt <= lt_cnt - LT_W'(1);
            end

            if (step) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == 3'(i)) begin
                        if (dir_q == DIR_INC)
                            cur_q[i] <= (cur_q[i] == LAST_P) ? '0 : cur_q[i] + PHASE_W'(1);
                        else
                            cur_q[i] <= (cur_q[i] == '0) ? LAST_P : cur_q[i] - PHASE_W'(1);
                    end
                end
            end
        end
    end

    // Outputs decoded from state; phase_sel/phase_dir hold the captured move.
    always_comb begin
        req_ready    = (state == ST_IDLE);
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
        err          = (state == ST_DONE) && err_q;
        load_phase   = (state == ST_LOAD);
        phase_sel    = ch_q;
        phase_dir    = dir_q;
        phase_step_n = step_n;
        for (int i = 0; i < NUM_CH; i++)
            cur_phase[i*PHASE_W +: PHASE_W] = cur_q[i];
    end

endmodule
